// File: rtl/tod_event_scheduler.sv
// tod_event_scheduler
// Broadcasts time-of-day as an event-code stream. Each pps emits a seconds
// marker, then SECONDS_WIDTH shift events (MSB first) that encode seconds+1,
// spaced BIT_SPACING cycles apart. A user event stream fills the idle slots.
//
// Optional feature macro: TOD_USER_EVENTS_EN
//   defined   - user events are merged into the idle slots of evCode
//   undefined - o_user_ev_code_ready is held at 0 and the user inputs are ignored
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_enable                1 = generate TOD events
//   i_pps                   top-of-second pulse
//   i_seconds_in/_load      value and strobe for the pending seconds load
//   i_user_ev_code/_valid   user event request
//   o_user_ev_code_ready    user event accepted when valid && ready (combinational)
//   o_ev_code/_valid        registered event code output
//   o_seconds               current second
//   o_shifting              shift sequence in progress
//   o_abort_counter         sequences aborted by pps (wraps)
module tod_event_scheduler #(
    parameter int unsigned SECONDS_WIDTH         = 32,
    parameter int unsigned BIT_SPACING           = 16,
    parameter logic [7:0]  EVCODE_SHIFT_ZERO     = 8'h70,
    parameter logic [7:0]  EVCODE_SHIFT_ONE      = 8'h71,
    parameter logic [7:0]  EVCODE_SECONDS_MARKER = 8'h7D,
    parameter int unsigned STATUS_COUNTER_WIDTH  = 10
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic                            i_pps,
    input  logic [SECONDS_WIDTH-1:0]        i_seconds_in,
    input  logic                            i_seconds_load,
    input  logic [7:0]                      i_user_ev_code,
    input  logic                            i_user_ev_code_valid,
    output logic                            o_user_ev_code_ready,
    output logic [7:0]                      o_ev_code,
    output logic                            o_ev_code_valid,
    output logic [SECONDS_WIDTH-1:0]        o_seconds,
    output logic                            o_shifting,
    output logic [STATUS_COUNTER_WIDTH-1:0] o_abort_counter
);

    localparam int unsigned SW  = SECONDS_WIDTH;
    localparam int unsigned CW  = STATUS_COUNTER_WIDTH;
    localparam int unsigned BCW = $clog2(SECONDS_WIDTH + 1);
    localparam int unsigned SPW = 8;

    localparam logic [SPW-1:0] SPACING_RELOAD = SPW'(BIT_SPACING - 1);
    localparam logic [BCW-1:0] BIT_LOAD       = BCW'(SECONDS_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state, w_state;
    logic [SPW-1:0]  r_spacing, w_spacing;
    logic [BCW-1:0]  r_bit_cnt, w_bit_cnt;
    logic [SW-1:0]   r_shift_reg, w_shift_reg;
    logic [SW-1:0]   r_seconds, w_seconds;
    logic [SW-1:0]   r_pending, w_pending;
    logic            r_pending_vld, w_pending_vld;
    logic [7:0]      r_ev_code, w_ev_code;
    logic            r_ev_valid, w_ev_valid;
    logic            r_shifting, w_shifting;
    logic [CW-1:0]   r_abort, w_abort;
    logic [SW-1:0]   w_next_seconds;
    logic            w_user_accept;

    // Ready must see this cycle's pps so a user event is never accepted into a marker slot.
`ifdef TOD_USER_EVENTS_EN
    assign o_user_ev_code_ready = ~i_rst & (~i_enable | (~i_pps & (r_state != ST_SHIFT)));
    assign w_user_accept        = o_user_ev_code_ready & i_user_ev_code_valid;
`else
    logic w_unused_user;
    assign w_unused_user        = ^{i_user_ev_code, i_user_ev_code_valid};
    assign o_user_ev_code_ready = 1'b0;
    assign w_user_accept        = 1'b0;
`endif

    // Value the next pps installs: a pending load wins over the increment.
    assign w_next_seconds = r_pending_vld ? r_pending : (r_seconds + SW'(1));

    // Next-state and output logic; later assignments carry higher priority.
    always_comb begin
        w_state       = r_state;
        w_spacing     = r_spacing;
        w_bit_cnt     = r_bit_cnt;
        w_shift_reg   = r_shift_reg;
        w_seconds     = r_seconds;
        w_pending     = r_pending;
        w_pending_vld = r_pending_vld;
        w_ev_code     = 8'h00;
        w_ev_valid    = 1'b0;
        w_abort       = r_abort;

        if (w_user_accept) begin
            w_ev_valid = 1'b1;
            w_ev_code  = i_user_ev_code;
        end

        if (!i_enable) begin
            w_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    w_spacing = r_spacing - SPW'(1);
                    if (r_spacing == SPW'(1)) begin
                        w_state = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w_ev_valid  = 1'b1;
                    w_ev_code   = r_shift_reg[SW-1] ? EVCODE_SHIFT_ONE : EVCODE_SHIFT_ZERO;
                    w_shift_reg = {r_shift_reg[SW-2:0], 1'b0};
                    w_bit_cnt   = r_bit_cnt - BCW'(1);
                    w_spacing   = SPACING_RELOAD;
                    w_state     = (r_bit_cnt == BCW'(1)) ? ST_DONE : ST_WAIT;
                end
                ST_DONE: w_state = ST_IDLE;
                default: w_state = ST_IDLE;
            endcase
        end

        // pps uses the pending value from before any coincident load.
        if (i_pps) begin
            w_seconds     = w_next_seconds;
            w_pending_vld = 1'b0;
            if (i_enable) begin
                if ((r_state == ST_WAIT) || (r_state == ST_SHIFT)) begin
                    w_abort = r_abort + CW'(1);
                end
                w_ev_valid  = 1'b1;
                w_ev_code   = EVCODE_SECONDS_MARKER;
                w_shift_reg = w_next_seconds + SW'(1);
                w_bit_cnt   = BIT_LOAD;
                w_spacing   = SPACING_RELOAD;
                w_state     = ST_WAIT;
            end
        end

        if (i_seconds_load) begin
            w_pending     = i_seconds_in;
            w_pending_vld = 1'b1;
        end

        w_shifting = (w_state == ST_WAIT) || (w_state == ST_SHIFT);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_spacing     <= '0;
            r_bit_cnt     <= '0;
            r_shift_reg   <= '0;
            r_seconds     <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
            r_ev_code     <= 8'h00;
            r_ev_valid    <= 1'b0;
            r_shifting    <= 1'b0;
            r_abort       <= '0;
        end else begin
            r_state       <= w_state;
            r_spacing     <= w_spacing;
            r_bit_cnt     <= w_bit_cnt;
            r_shift_reg   <= w_shift_reg;
            r_seconds     <= w_seconds;
            r_pending     <= w_pending;
            r_pending_vld <= w_pending_vld;
            r_ev_code     <= w_ev_code;
            r_ev_valid    <= w_ev_valid;
            r_shifting    <= w_shifting;
            r_abort       <= w_abort;
        end
    end

    assign o_ev_code       = r_ev_code;
    assign o_ev_code_valid = r_ev_valid;
    assign o_seconds       = r_seconds;
    assign o_shifting      = r_shifting;
    assign o_abort_counter = r_abort;

endmodule
